apb_requester: RTL and testbench
================================

// Module: apb_requester
// PURPOSE
//  APB4 initiator: the requester side of the APB slave port on matmul.
//  Takes one command (addr/write/data/strb) on a valid/ready port, runs APB SETUP->ACCESS,
//  waits on pready_i with an optional timeout, and returns rdata/error on a valid/ready port.
//  Used as the host-side bridge that programs and reads matmul; synthesizable, also reused in benches.
// PARAMETERS
//  BUS_WIDTH       32  APB data width, bits (multiple of 8)
//  ADDR_WIDTH      32  APB address width, bits
//  TIMEOUT_CYCLES  16  max ACCESS cycles without pready_i before abort; 0 disables the timeout
// PORTS
//  clk_i          in   1             clock, all logic on rising edge
//  rst_ni         in   1             asynchronous active-low reset
//  cmd_valid_i    in   1             command present
//  cmd_ready_o    out  1             command accepted when valid&ready
//  cmd_addr_i     in   ADDR_WIDTH    target address
//  cmd_write_i    in   1             1=write, 0=read
//  cmd_wdata_i    in   BUS_WIDTH     write data
//  cmd_strb_i     in   BUS_WIDTH/8   write byte enables
//  rsp_valid_o    out  1             response present
//  rsp_ready_i    in   1             response consumed when valid&ready
//  rsp_rdata_o    out  BUS_WIDTH     read data (0 for writes)
//  rsp_err_o      out  1             pslverr_i seen or timeout
//  rsp_timeout_o  out  1             abort caused by timeout
//  paddr_o        out  ADDR_WIDTH    APB paddr
//  psel_o         out  1             APB psel
//  penable_o      out  1             APB penable
//  pwrite_o       out  1             APB pwrite
//  pwdata_o       out  BUS_WIDTH     APB pwdata
//  pstrb_o        out  BUS_WIDTH/8   APB pstrb
//  pready_i       in   1             APB pready
//  pslverr_i      in   1             APB pslverr
//  prdata_i       in   BUS_WIDTH     APB prdata
//  busy_o         out  1             transfer in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): every output 0 at once, mid-transfer included; FSM->IDLE, timer cleared.
//    After release cmd_ready_o=1. A transfer cut off by reset is never reported.
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: cmd_ready_o=1, psel_o=penable_o=0.
//    On valid&ready, register addr/write/wdata/strb and go to SETUP.
//  - SETUP (1 cycle): psel_o=1, penable_o=0, address/control/data on the bus.
//  - ACCESS: psel_o=1, penable_o=1.
//    paddr/pwrite/pwdata/pstrb stay unchanged from SETUP until the transfer completes.
//  - ACCESS, pready_i=1: capture prdata_i (reads only; writes return 0) and pslverr_i.
//    Next cycle: psel_o=penable_o=0, state RESP.
//  - ACCESS, pready_i=0: timer increments.
//    If timer==TIMEOUT_CYCLES (and TIMEOUT_CYCLES!=0): abort to RESP, rsp_err_o=1, rsp_timeout_o=1, rdata=0.
//  - pready_i on the cycle the timer expires: normal completion wins.
//  - RESP: rsp_valid_o=1. Data/err/timeout stay stable until rsp_ready_i=1, then go to IDLE.
//    cmd_ready_o=0 and no new psel while in RESP.
//  - Reads drive pstrb_o=0 (APB4 rule). Writes drive pstrb_o=cmd_strb_i.
//    pwdata_o=0 during reads. Bus outputs return to 0 in IDLE.
//  - Timing: command accepted at cycle N; psel at N+1; penable at N+2.
//    With zero wait states rsp_valid_o at N+3. Each wait state adds one cycle.
//    Minimum 4 cycles per transfer. One transfer outstanding at most.
//  - Timer width: $clog2(TIMEOUT_CYCLES+1), minimum 1. Cleared on entering SETUP; saturates, never wraps.
//  - pslverr_i is sampled only when penable_o&pready_i; it is ignored at every other time.
// STRUCTURE
//  - Shared package (next to BUS_WIDTH/ADDR_WIDTH): apb_state_e {IDLE,SETUP,ACCESS,RESP},
//    apb_cmd_t {addr,write,wdata,strb}, apb_rsp_t {rdata,err,timeout}, APB_TIMEOUT_DEFAULT.
//  - Sub-module apb_wait_timer: clear/enable/expired counter, parameterised by TIMEOUT_CYCLES.
// TESTING
//  - Write addr 0x10, data 0xDEADBEEF, strb 0xF, pready tied 1:
//    psel rises N+1, penable N+2, rsp_valid N+3, rsp_err 0, rdata 0.
//  - Read addr 0x20, pready low 3 ACCESS cycles, prdata 0x12345678:
//    rsp_valid at N+6 with rdata 0x12345678, pstrb 0 throughout, paddr stable.
//  - Write with pslverr=1 and pready=1: rsp_err 1, rsp_timeout 0; next command accepted after rsp handshake.
//  - TIMEOUT_CYCLES=8, pready held 0: abort after 8 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1.
//  - rsp_ready held 0 for 5 cycles with cmd_valid=1:
//    rsp stays stable, cmd_ready 0, no psel, then exactly one new SETUP.
//  - rst_ni pulled low mid-ACCESS: psel/penable/rsp_valid/busy go 0 without waiting for clk_i;
//    after release cmd_ready=1, no stale response.

Source files
------------

// File: rtl/apb_requester_pkg.sv
// Shared types and defaults for the APB requester and the benches that drive it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default bus widths, FSM state encoding, command/response records,
//           and the wait-timer width helper.

package apb_requester_pkg;

  localparam int APB_BUS_WIDTH       = 32;
  localparam int APB_ADDR_WIDTH      = 32;
  localparam int APB_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0]  addr;
    logic                       write;
    logic [APB_BUS_WIDTH-1:0]   wdata;
    logic [APB_BUS_WIDTH/8-1:0] strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_BUS_WIDTH-1:0] rdata;
    logic                     err;
    logic                     timeout;
  } apb_rsp_t;

  // Counter width able to hold 0..cycles; never narrower than one bit so a
  // disabled timeout (cycles == 0) still elaborates.
  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_requester_wait_timer.sv
// Counts ACCESS cycles spent waiting for pready and flags the cycle on which the limit is hit.
// Latency: expired is combinational on the counting cycle (count incl. this cycle == limit).
// Backpressure: none; clear has priority over enable, count saturates instead of wrapping.
// Ports: clk, rst_n (async active-low), clear (restart at 0), enable (one more wait cycle),
//        expired (this wait cycle is the TIMEOUT_CYCLES-th; never asserted when TIMEOUT_CYCLES == 0).

module apb_wait_timer
  import apb_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = timer_width(TIMEOUT_CYCLES);
  // The abort decision is made on the cycle whose increment would bring the
  // count to TIMEOUT_CYCLES, so the limit counts ACCESS cycles exactly.
  localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB4 initiator: one command in on valid/ready, SETUP->ACCESS on APB, one response out on valid/ready.
// Latency: accept at N, psel N+1, penable N+2, rsp_valid N+3 plus one cycle per wait state.
// Backpressure: one transfer outstanding; cmd_ready_o stays low until the response is taken.
// Ports: clk_i/rst_ni; cmd_* command port; rsp_* response port; p* APB4 requester signals;
//        busy_o high from command accept until the response handshake.

module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int BUS_WIDTH      = APB_BUS_WIDTH,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
  input  logic                   cmd_write_i,
  input  logic [BUS_WIDTH-1:0]   cmd_wdata_i,
  input  logic [BUS_WIDTH/8-1:0] cmd_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]  paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [BUS_WIDTH-1:0]   pwdata_o,
  output logic [BUS_WIDTH/8-1:0] pstrb_o,
  input  logic                   pready_i,
  input  logic                   pslverr_i,
  input  logic [BUS_WIDTH-1:0]   prdata_i,
  output logic                   busy_o
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  // Registered APB address/control/data; held from SETUP until completion.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [STRB_WIDTH-1:0] strb;
  } bus_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] rdata;
    logic                 err;
    logic                 timeout;
  } rsp_t;

  apb_state_e state;
  bus_t       bus;
  rsp_t       rsp;
  logic       psel;
  logic       penable;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       busy;

  logic accept;
  logic wait_cycle;
  logic expired;
  logic done;

  assign accept     = (state == IDLE) && cmd_ready && cmd_valid_i;
  assign wait_cycle = (state == ACCESS) && !pready_i;
  // pready wins over an expiring timer on the same cycle.
  assign done       = (state == ACCESS) && (pready_i || expired);

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (accept),
    .enable (wait_cycle),
    .expired(expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      bus       <= '0;
      rsp       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            busy      <= 1'b1;
            state     <= SETUP;
            bus.addr  <= cmd_addr_i;
            bus.write <= cmd_write_i;
            // Reads never carry data or byte strobes on the bus.
            bus.wdata <= cmd_write_i ? cmd_wdata_i : '0;
            bus.strb  <= cmd_write_i ? cmd_strb_i : '0;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (done) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            bus         <= '0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
            // prdata/pslverr are only meaningful when pready closes the access;
            // an abort returns zero data with both error flags.
            rsp.rdata   <= (pready_i && !bus.write) ? prdata_i : '0;
            rsp.err     <= pready_i ? pslverr_i : 1'b1;
            rsp.timeout <= !pready_i;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid <= 1'b0;
            rsp       <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready;
  assign rsp_valid_o   = rsp_valid;
  assign rsp_rdata_o   = rsp.rdata;
  assign rsp_err_o     = rsp.err;
  assign rsp_timeout_o = rsp.timeout;
  assign paddr_o       = bus.addr;
  assign pwrite_o      = bus.write;
  assign pwdata_o      = bus.wdata;
  assign pstrb_o       = bus.strb;
  assign psel_o        = psel;
  assign penable_o     = penable;
  assign busy_o        = busy;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed vector table, hand sequences for stall and reset,
// and randomized transfers checked against a transaction-level reference model.
// The bench plays the APB completer, inserting a chosen number of wait states.

module tb_apb_requester;
  import apb_requester_pkg::*;

  localparam int TMO = 8;

  logic        clk_i;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic        cmd_write_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic        pslverr_i;
  logic [31:0] prdata_i;
  logic        busy_o;

  apb_requester #(
    .BUS_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_write_i(cmd_write_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .prdata_i(prdata_i), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: the completer either answers after 'waits'
  // wait states or the requester gives up after TMO ACCESS cycles.
  function automatic void ref_model(input apb_cmd_t c, input int waits, input logic [31:0] rd,
                                    input logic serr, output apb_rsp_t r, output int lat);
    if (waits >= TMO) begin
      r.rdata = '0; r.err = 1'b1; r.timeout = 1'b1;
      lat = 2 + TMO;
    end else begin
      r.rdata = c.write ? 32'h0 : rd; r.err = serr; r.timeout = 1'b0;
      lat = 3 + waits;
    end
  endfunction

  task automatic drive_noise();
    pready_i  = 1'($urandom);
    pslverr_i = 1'($urandom);
    prdata_i  = $urandom;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // One complete transfer: issue, play completer, hold the response, consume it.
  task automatic do_txn(input string tag, input apb_cmd_t c, input int waits, input logic [31:0] rd,
                        input logic serr, input int hold, input apb_rsp_t er, input int elat);
    int k, acc, psel_n, pen_n, lat;
    logic bus_ok, hold_ok;
    apb_rsp_t got;
    @(negedge clk_i);
    check($sformatf("%s.cmd_ready", tag), 128'(cmd_ready_o), 128'd1);
    cmd_valid_i = 1'b1; cmd_addr_i = c.addr; cmd_write_i = c.write;
    cmd_wdata_i = c.wdata; cmd_strb_i = c.strb; rsp_ready_i = 1'b0;
    drive_noise();
    @(negedge clk_i);
    cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_wdata_i = $urandom; cmd_strb_i = 4'($urandom);
    cmd_write_i = 1'($urandom);
    k = 1; acc = 0; psel_n = 0; pen_n = 0; lat = 0; bus_ok = 1'b1;
    while (lat == 0 && k <= 40) begin
      if (rsp_valid_o) begin
        lat = k;
      end else begin
        if (psel_o) begin
          psel_n++;
          if (paddr_o !== c.addr || pwrite_o !== c.write ||
              pwdata_o !== (c.write ? c.wdata : 32'h0) || pstrb_o !== (c.write ? c.strb : 4'h0))
            bus_ok = 1'b0;
        end
        if (penable_o) pen_n++;
        if (psel_o && penable_o) begin
          acc++;
          pready_i  = (acc > waits);
          pslverr_i = pready_i ? serr : 1'($urandom);
          prdata_i  = pready_i ? rd : $urandom;
        end else begin
          drive_noise();
        end
        @(negedge clk_i);
        k++;
      end
    end
    if (lat == 0) begin
      check($sformatf("%s.rsp_seen", tag), 128'd0, 128'd1);
      do_reset();
      return;
    end
    got = '{rdata: rsp_rdata_o, err: rsp_err_o, timeout: rsp_timeout_o};
    check($sformatf("%s.latency", tag), 128'(lat), 128'(elat));
    check($sformatf("%s.rdata", tag), 128'(got.rdata), 128'(er.rdata));
    check($sformatf("%s.err_timeout", tag), 128'({got.err, got.timeout}), 128'({er.err, er.timeout}));
    check($sformatf("%s.bus_stable", tag), 128'(bus_ok), 128'd1);
    check($sformatf("%s.psel_cycles", tag), 128'(psel_n), 128'(elat - 1));
    check($sformatf("%s.penable_cycles", tag), 128'(pen_n), 128'(elat - 2));
    check($sformatf("%s.resp_state", tag), 128'({busy_o, psel_o, cmd_ready_o}), 128'(3'b100));
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      drive_noise();
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== got.rdata || rsp_err_o !== got.err ||
          rsp_timeout_o !== got.timeout || cmd_ready_o !== 1'b0 || psel_o !== 1'b0)
        hold_ok = 1'b0;
    end
    check($sformatf("%s.hold", tag), 128'(hold_ok), 128'd1);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check($sformatf("%s.idle_after", tag), 128'({rsp_valid_o, busy_o, cmd_ready_o}), 128'(3'b001));
  endtask

  typedef struct {
    string    name;
    apb_cmd_t cmd;
    int       waits;
    logic [31:0] rd;
    logic     serr;
    int       hold;
    apb_rsp_t exp;
    int       lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    apb_cmd_t c;
    apb_rsp_t r;
    int lat, n, setups, rsps;
    logic ok;
    logic [31:0] saw_addr;

    vecs[0] = '{"wr_zero_wait", '{32'h10, 1'b1, 32'hDEADBEEF, 4'hF}, 0, 32'h0, 1'b0, 0, '{32'h0, 1'b0, 1'b0}, 3};
    vecs[1] = '{"rd_3_waits", '{32'h20, 1'b0, 32'h0, 4'h0}, 3, 32'h12345678, 1'b0, 1, '{32'h12345678, 1'b0, 1'b0}, 6};
    vecs[2] = '{"wr_slverr", '{32'h24, 1'b1, 32'h0BADF00D, 4'h5}, 0, 32'hFFFFFFFF, 1'b1, 0, '{32'h0, 1'b1, 1'b0}, 3};
    vecs[3] = '{"rd_timeout", '{32'h28, 1'b0, 32'h0, 4'h0}, 30, 32'hCAFEBABE, 1'b0, 2, '{32'h0, 1'b1, 1'b1}, 10};
    vecs[4] = '{"rd_ready_at_expiry", '{32'h2C, 1'b0, 32'h0, 4'hF}, 7, 32'hA1B2C3D4, 1'b0, 0, '{32'hA1B2C3D4, 1'b0, 1'b0}, 10};
    vecs[5] = '{"rd_slverr_waits", '{32'h40, 1'b0, 32'h0, 4'h0}, 2, 32'h55AA00FF, 1'b1, 0, '{32'h55AA00FF, 1'b1, 1'b0}, 5};
    vecs[6] = '{"wr_timeout", '{32'h44, 1'b1, 32'h13579BDF, 4'h9}, 20, 32'h0, 1'b0, 3, '{32'h0, 1'b1, 1'b1}, 10};

    rst_ni = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_write_i = 1'b0; cmd_wdata_i = '0;
    cmd_strb_i = '0; rsp_ready_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    #2 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset.outputs", {cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, paddr_o,
                            psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, busy_o}, 128'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("reset.cmd_ready_after", 128'(cmd_ready_o), 128'd1);

    foreach (vecs[i])
      do_txn(vecs[i].name, vecs[i].cmd, vecs[i].waits, vecs[i].rd, vecs[i].serr,
             vecs[i].hold, vecs[i].exp, vecs[i].lat);

    // Command waiting while the response is stalled: nothing starts until the
    // response is taken, then exactly one new SETUP for the waiting command.
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_addr_i = 32'h30; cmd_write_i = 1'b1; cmd_wdata_i = 32'hA5A5A5A5;
    cmd_strb_i = 4'h3; rsp_ready_i = 1'b0; pready_i = 1'b1; pslverr_i = 1'b0;
    @(negedge clk_i);
    cmd_addr_i = 32'h34; cmd_wdata_i = 32'h5A5A5A5A; cmd_strb_i = 4'hC;
    n = 0;
    while (!rsp_valid_o && n < 10) begin @(negedge clk_i); n++; end
    check("stall.rsp_seen", 128'(rsp_valid_o), 128'd1);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0 ||
          cmd_ready_o !== 1'b0 || psel_o !== 1'b0) ok = 1'b0;
    end
    check("stall.hold_stable", 128'(ok), 128'd1);
    rsp_ready_i = 1'b1;
    setups = 0; rsps = 0; saw_addr = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (psel_o && !penable_o) begin setups++; saw_addr = paddr_o; cmd_valid_i = 1'b0; end
      if (rsp_valid_o) rsps++;
    end
    rsp_ready_i = 1'b0;
    check("stall.one_setup", 128'(setups), 128'd1);
    check("stall.next_addr", 128'(saw_addr), 128'h34);
    check("stall.second_rsp", 128'(rsps), 128'd1);

    // Reset in the middle of ACCESS: outputs drop without a clock edge and the
    // interrupted transfer never produces a response.
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_addr_i = 32'h50; cmd_write_i = 1'b0; pready_i = 1'b0;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_mid.in_access", 128'({psel_o, penable_o, busy_o}), 128'(3'b111));
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid.async_drop", 128'({psel_o, penable_o, rsp_valid_o, busy_o, cmd_ready_o}), 128'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pready_i = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o || psel_o || busy_o) ok = 1'b0;
    end
    check("rst_mid.no_stale_rsp", 128'(ok), 128'd1);
    check("rst_mid.cmd_ready", 128'(cmd_ready_o), 128'd1);

    for (int t = 0; t < 40; t++) begin
      int w, h;
      logic [31:0] rd;
      logic se;
      c.addr = $urandom; c.write = 1'($urandom); c.wdata = $urandom; c.strb = 4'($urandom);
      w = $urandom_range(0, 11); rd = $urandom; se = 1'($urandom); h = $urandom_range(0, 3);
      ref_model(c, w, rd, se, r, lat);
      do_txn($sformatf("rand%0d", t), c, w, rd, se, h, r, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
